// File: rtl/encoded_memory_controller_pkg.sv
//------------------------------------------------------------------------------
// Module : encoded_memory_controller_pkg
// Brief  : Command opcodes, FSM state encoding and width defaults shared by
//          the EncodedMemory command sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package encoded_memory_controller_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_FILL = 2'b10,
        OP_DUMP = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_FILL    = 3'd2,
        S_RDADDR  = 3'd3,
        S_RDCAP   = 3'd4,
        S_RSPWAIT = 3'd5
    } state_e;

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_WR) || (op == OP_FILL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/encoded_memory_controller_wrap_counter.sv
//------------------------------------------------------------------------------
// Module : encoded_memory_controller_wrap_counter
// Brief  : Modular load/increment counter with an all-ones terminal flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module encoded_memory_controller_wrap_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    logic [WIDTH-1:0] r_count;

    // Load wins over increment; increment wraps naturally at 2**WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign term  = &r_count;

endmodule

`default_nettype wire

// File: rtl/encoded_memory_controller.sv
//------------------------------------------------------------------------------
// Module : encoded_memory_controller
// Brief  : Single/burst write and read sequencer driving EncodedMemory pins,
//          with a registered valid/ready response channel.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module encoded_memory_controller
    import encoded_memory_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_index,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_index,
    output logic              rsp_last,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_index,
    output logic [DATA_W-1:0] mem_number,
    input  logic [DATA_W-1:0] mem_result
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_mem_mode;
    logic [DATA_W-1:0]   r_mem_number;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [ADDR_W-1:0]   r_rsp_index;
    logic                r_rsp_last;
    logic                r_is_dump;

    logic                w_hs;
    logic                w_idx_load;
    logic                w_idx_inc;
    logic                w_beat_load;
    logic                w_beat_inc;
    logic                w_num_load;
    logic                w_mode_wr;
    logic                w_mode_rd;
    logic                w_capture;
    logic                w_rsp_clr;
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_beat;
    logic                w_beat_term;
    logic                w_idx_term_unused;

    assign cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
    assign w_hs      = cmd_valid && cmd_ready;

    encoded_memory_controller_wrap_counter #(.WIDTH(ADDR_W)) u_index_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_idx_load),
        .load_val (cmd_index),
        .inc      (w_idx_inc),
        .count    (w_idx),
        .term     (w_idx_term_unused)
    );

    encoded_memory_controller_wrap_counter #(.WIDTH(ADDR_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_beat_load),
        .load_val ('0),
        .inc      (w_beat_inc),
        .count    (w_beat),
        .term     (w_beat_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_load  = 1'b0;
        w_idx_inc   = 1'b0;
        w_beat_load = 1'b0;
        w_beat_inc  = 1'b0;
        w_num_load  = 1'b0;
        w_mode_wr   = 1'b0;
        w_mode_rd   = 1'b0;
        w_capture   = 1'b0;
        w_rsp_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_idx_load  = 1'b1;
                    w_beat_load = 1'b1;
                    if (op_is_write(cmd_op)) begin
                        w_num_load = 1'b1;
                        w_mode_wr  = 1'b1;
                    end
                    case (cmd_op)
                        OP_WR:   w_state_nxt = S_WRITE;
                        OP_FILL: w_state_nxt = S_FILL;
                        default: w_state_nxt = S_RDCAP;
                    endcase
                end
            end
            S_WRITE: begin
                w_mode_rd   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FILL: begin
                // Every FILL cycle is a write edge; leave after the eighth.
                w_idx_inc  = 1'b1;
                w_beat_inc = 1'b1;
                if (w_beat_term) begin
                    w_mode_rd   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RDADDR: begin
                w_state_nxt = S_RDCAP;
            end
            S_RDCAP: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RSPWAIT;
            end
            S_RSPWAIT: begin
                if (rsp_ready) begin
                    w_rsp_clr = 1'b1;
                    if (!r_is_dump || w_beat_term) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_beat_inc  = 1'b1;
                        w_state_nxt = S_RDCAP;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_mode   <= 1'b1;
            r_mem_number <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_index  <= '0;
            r_rsp_last   <= 1'b0;
            r_is_dump    <= 1'b0;
        end else begin
            if (w_mode_wr) begin
                r_mem_mode <= 1'b0;
            end else if (w_mode_rd) begin
                r_mem_mode <= 1'b1;
            end
            if (w_num_load) begin
                r_mem_number <= cmd_data;
            end
            if (w_idx_load) begin
                r_is_dump <= (cmd_op == OP_DUMP);
            end
            // EncodedMemory's Result is combinational on the index already on the pins.
            if (w_capture) begin
                r_rsp_data  <= mem_result;
                r_rsp_index <= w_idx;
                r_rsp_valid <= 1'b1;
                r_rsp_last  <= !r_is_dump || w_beat_term;
            end else if (w_rsp_clr) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign mem_mode   = r_mem_mode;
    assign mem_index  = w_idx;
    assign mem_number = r_mem_number;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_index  = r_rsp_index;
    assign rsp_last   = r_rsp_last;

endmodule

`default_nettype wire

// File: tb/tb_encoded_memory_controller.sv
//------------------------------------------------------------------------------
// Module : tb_encoded_memory_controller
// Brief  : Directed bench for encoded_memory_controller with an EncodedMemory
//          stand-in and an address-level reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_encoded_memory_controller;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [7:0] ROM  [8] = '{8'h00, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0, 8'hFF};
    localparam logic [7:0] EXP2 [8] = '{8'hAA, 8'hFF, 8'h00, 8'h99, 8'h66, 8'hA5, 8'h5A, 8'h55};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_index;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_last;
    logic [7:0] rsp_data;
    logic [2:0] rsp_index;
    logic       mem_mode;
    logic [2:0] mem_index;
    logic [7:0] mem_number, mem_result;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  store [8];
    logic [7:0]  model_mem [8];
    logic [7:0]  snap [8];
    logic [10:0] wq [$];
    logic [11:0] rq [$];
    logic [11:0] rlog [$];
    time         accept_time, last_hs_time;

    initial forever #5 clk = ~clk;

    encoded_memory_controller #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_index  (cmd_index),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_index  (rsp_index),
        .rsp_last   (rsp_last),
        .mem_mode   (mem_mode),
        .mem_index  (mem_index),
        .mem_number (mem_number),
        .mem_result (mem_result)
    );

    // EncodedMemory stand-in: raw store, XOR-decoded on read.
    initial begin
        for (int i = 0; i < 8; i++) begin
            store[i]     = 8'h00;
            model_mem[i] = 8'h00;
        end
        forever begin
            @(posedge clk);
            if (!mem_mode) store[mem_index] = mem_number;
        end
    end
    assign mem_result = store[mem_index] ^ ROM[mem_index];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Issue one command and record what it must do to the memory and response channel.
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] data);
        logic       rdy;
        bit         acc;
        logic [2:0] j;
        cmd_op    = op;
        cmd_index = idx;
        cmd_data  = data;
        cmd_valid = 1'b1;
        acc       = 1'b0;
        for (int t = 0; t < 200; t++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            fail("cmd_accept_timeout");
        end else begin
            accept_time = $time;
            case (op)
                OP_WR: begin
                    model_mem[idx] = data;
                    wq.push_back({idx, data});
                end
                OP_RD: rq.push_back({1'b1, idx, model_mem[idx] ^ ROM[idx]});
                OP_FILL: begin
                    for (int i = 0; i < 8; i++) begin
                        j = idx + 3'(i);
                        model_mem[j] = data;
                        wq.push_back({j, data});
                    end
                end
                default: begin
                    for (int i = 0; i < 8; i++) begin
                        j = idx + 3'(i);
                        rq.push_back({(i == 7), j, model_mem[j] ^ ROM[j]});
                    end
                end
            endcase
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !cmd_ready) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 400) fail("wait_done_timeout");
    endtask

    // Per-cycle compare: write slots, response stability and response beats.
    initial begin : compare
        logic        p_valid, p_ready;
        logic [11:0] p_data, e12;
        logic [10:0] e11;
        p_valid = 1'b0;
        p_ready = 1'b1;
        p_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_valid = 1'b0;
            end else begin
                if (!mem_mode) begin
                    if (wq.size() == 0) begin
                        fail("unexpected_write");
                    end else begin
                        e11 = wq.pop_front();
                        check("write_slot", 32'({mem_index, mem_number}), 32'(e11));
                    end
                end
                if (p_valid && !p_ready)
                    check("rsp_hold", 32'({rsp_valid, rsp_last, rsp_index, rsp_data}), 32'({1'b1, p_data}));
                if (rsp_valid && rsp_ready) begin
                    if (rq.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        e12 = rq.pop_front();
                        check("rsp_beat", 32'({rsp_last, rsp_index, rsp_data}), 32'(e12));
                        rlog.push_back({rsp_last, rsp_index, rsp_data});
                        last_hs_time = $time;
                    end
                end
                p_valid = rsp_valid;
                p_ready = rsp_ready;
                p_data  = {rsp_last, rsp_index, rsp_data};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         beats;
        bit         held;
        logic [11:0] hd;
        cmd_valid    = 1'b0;
        cmd_op       = OP_WR;
        cmd_index    = '0;
        cmd_data     = '0;
        rsp_ready    = 1'b1;
        accept_time  = 0;
        last_hs_time = 0;

        // Reset asserted between clock edges
        #1 rst_n = 1'b0;
        #1;
        check("rst_mem_mode", 32'(mem_mode), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_index", 32'(mem_index), 32'd0);
        check("rst_rsp_regs", 32'({rsp_last, rsp_index, rsp_data}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset landing in the middle of a single write
        cmd_op = OP_WR; cmd_index = 3'd5; cmd_data = 8'h5A; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("wr_mode_low", 32'(mem_mode), 32'd0);
        check("wr_mem_index", 32'(mem_index), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_mode", 32'(mem_mode), 32'd1);
        check("midrst_mem_index", 32'(mem_index), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_mem_number", 32'(mem_number), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FILL from 7 with wrap, then DUMP from 0
        send_cmd(OP_FILL, 3'd7, 8'hAA);
        wait_done();
        rlog.delete();
        send_cmd(OP_DUMP, 3'd0, 8'h00);
        wait_done();
        check("dump_beats", 32'(rlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < rlog.size(); i++) begin
            check("dump_data", 32'(rlog[i][7:0]), 32'(EXP2[i]));
            check("dump_last", 32'(rlog[i][11]), 32'(i == 7));
        end

        // Single write then read back
        send_cmd(OP_WR, 3'd3, 8'h3C);
        check("wr_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("wr_ready_back", 32'(cmd_ready), 32'd1);
        rlog.delete();
        send_cmd(OP_RD, 3'd3, 8'h00);
        wait_done();
        check("rd_count", 32'(rlog.size()), 32'd1);
        if (rlog.size() > 0) check("rd_result", 32'(rlog[0]), 32'({1'b1, 3'd3, 8'h0F}));

        // DUMP with a 5-cycle stall on beat 2
        rlog.delete();
        send_cmd(OP_DUMP, 3'd5, 8'h00);
        beats = 0;
        held  = 1'b0;
        hd    = '0;
        for (int t = 0; t < 100 && !held; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                if (beats == 2) begin
                    rsp_ready = 1'b0;
                    hd = {rsp_last, rsp_index, rsp_data};
                    repeat (5) begin
                        @(posedge clk); #1;
                        check("stall_hold", 32'({rsp_valid, rsp_last, rsp_index, rsp_data}), 32'({1'b1, hd}));
                        check("stall_mode", 32'(mem_mode), 32'd1);
                    end
                    rsp_ready = 1'b1;
                    held = 1'b1;
                end else begin
                    beats++;
                end
            end
        end
        if (!held) fail("stall_beat_not_seen");
        check("stall_index", 32'(hd[10:8]), 32'd7);
        wait_done();
        check("stall_beats", 32'(rlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < rlog.size(); i++)
            check("stall_seq_index", 32'(rlog[i][10:8]), 32'((5 + i) % 8));

        // Reset after three FILL write edges
        snap = model_mem;
        send_cmd(OP_FILL, 3'd0, 8'h11);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("fill_abort_mode", 32'(mem_mode), 32'd1);
        wq.delete();
        model_mem = snap;
        for (int i = 0; i < 3; i++) model_mem[i] = 8'h11;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rlog.delete();
        send_cmd(OP_RD, 3'd2, 8'h00);
        send_cmd(OP_RD, 3'd4, 8'h00);
        wait_done();
        check("abort_rd_count", 32'(rlog.size()), 32'd2);
        if (rlog.size() > 1) begin
            check("abort_rd2", 32'(rlog[0][7:0]), 32'h0BB);
            check("abort_rd4", 32'(rlog[1][7:0]), 32'h066);
        end

        // WR held while a response is pending
        rlog.delete();
        rsp_ready = 1'b0;
        send_cmd(OP_RD, 3'd0, 8'h00);
        cmd_op = OP_WR; cmd_index = 3'd6; cmd_data = 8'h77; cmd_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("blocked_ready", 32'(cmd_ready), 32'd0);
            check("blocked_mode", 32'(mem_mode), 32'd1);
        end
        check("blocked_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        send_cmd(OP_WR, 3'd6, 8'h77);
        check("wr_after_rsp", 32'(accept_time > last_hs_time), 32'd1);
        send_cmd(OP_RD, 3'd6, 8'h00);
        wait_done();
        check("blocked_rd_count", 32'(rlog.size()), 32'd2);
        if (rlog.size() > 1) begin
            check("blocked_rd0", 32'(rlog[0][7:0]), 32'h011);
            check("blocked_rd6", 32'(rlog[1][7:0]), 32'h087);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
